// File: rtl/uart_key_decoder_if.sv
// Byte handshake and note-event bundle between the piano UART
// receiver, the key decoder and the tone generator.
interface uart_key_decoder_if;
  logic [7:0] d_in;
  logic       ready;
  logic       ack;
  logic       note_on;
  logic [3:0] note_idx;
  logic [1:0] octave;
  logic       key_strobe;
  logic       byte_err;

  modport master (
    output d_in, ready,
    input  ack, note_on, note_idx, octave,
    input  key_strobe, byte_err
  );

  modport slave (
    input  d_in, ready,
    output ack, note_on, note_idx, octave,
    output key_strobe, byte_err
  );
endinterface

// File: rtl/uart_key_decoder.sv
// Maps ASCII keyboard bytes from the piano UART to note events,
// with octave shift, explicit note-off and sustain auto-release.
module uart_key_decoder #(
  parameter int SUSTAIN_CYCLES = 25000000,
  parameter int TIMER_W        = 25
) (
  input  logic          clk,
  input  logic          rst,
  uart_key_decoder_if.slave kb
);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    WAIT_LOW
  } state_t;

  state_t state;

  logic               sync1, sync2, sync3;
  logic               rdy_rise;
  logic [7:0]         byte_q;
  logic [TIMER_W-1:0] timer;

  logic       ack_q;
  logic       note_on_q;
  logic [3:0] note_idx_q;
  logic [1:0] octave_q;
  logic       key_strobe_q;
  logic       byte_err_q;

  logic       is_note;
  logic [3:0] note_map;

  assign rdy_rise = sync2 & ~sync3;

  always_comb begin
    is_note  = 1'b1;
    note_map = 4'd0;
    case (byte_q)
      8'h61: note_map = 4'd0;
      8'h77: note_map = 4'd1;
      8'h73: note_map = 4'd2;
      8'h65: note_map = 4'd3;
      8'h64: note_map = 4'd4;
      8'h66: note_map = 4'd5;
      8'h74: note_map = 4'd6;
      8'h67: note_map = 4'd7;
      8'h79: note_map = 4'd8;
      8'h68: note_map = 4'd9;
      8'h75: note_map = 4'd10;
      8'h6A: note_map = 4'd11;
      8'h6B: note_map = 4'd12;
      default: is_note = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      sync3        <= 1'b0;
      byte_q       <= 8'h00;
      timer        <= '0;
      ack_q        <= 1'b1;
      note_on_q    <= 1'b0;
      note_idx_q   <= 4'd0;
      octave_q     <= 2'd1;
      key_strobe_q <= 1'b0;
      byte_err_q   <= 1'b0;
    end else begin
      sync1        <= kb.ready;
      sync2        <= sync1;
      sync3        <= sync2;
      key_strobe_q <= 1'b0;
      byte_err_q   <= 1'b0;

      // Sustain countdown; a note key decoded on the expiry edge
      // overrides the release below.
      if (note_on_q && timer != '0) begin
        timer <= timer - 1'b1;
        if (timer == TIMER_W'(1))
          note_on_q <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (rdy_rise) begin
            byte_q <= kb.d_in;
            state  <= DECODE;
            ack_q  <= 1'b0;
          end
        end
        DECODE: begin
          state <= WAIT_LOW;
          if (is_note) begin
            note_idx_q   <= note_map;
            note_on_q    <= 1'b1;
            timer        <= TIMER_W'(SUSTAIN_CYCLES);
            key_strobe_q <= 1'b1;
          end else if (byte_q == 8'h20) begin
            note_on_q <= 1'b0;
            timer     <= '0;
          end else if (byte_q == 8'h2B) begin
            if (octave_q != 2'd2)
              octave_q <= octave_q + 2'd1;
          end else if (byte_q == 8'h2D) begin
            if (octave_q != 2'd0)
              octave_q <= octave_q - 2'd1;
          end else begin
            byte_err_q <= 1'b1;
          end
        end
        WAIT_LOW: begin
          if (!sync2) begin
            state <= IDLE;
            ack_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign kb.ack        = ack_q;
  assign kb.note_on    = note_on_q;
  assign kb.note_idx   = note_idx_q;
  assign kb.octave     = octave_q;
  assign kb.key_strobe = key_strobe_q;
  assign kb.byte_err   = byte_err_q;

endmodule

// File: tb/tb_uart_key_decoder.sv
// Scoreboard bench for uart_key_decoder: each byte pushes its expected
// outcome, a monitor checks it when ack returns high.
module tb_uart_key_decoder;

  localparam int SUS = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  uart_key_decoder_if ifc ();

  uart_key_decoder #(
    .SUSTAIN_CYCLES(SUS),
    .TIMER_W       (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kb (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int idx;
    int oct;
    int on;
    int ks;
    int be;
    int low;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int n_chk  = 0;
  int n_fail = 0;
  int ks_c   = 0;
  int be_c   = 0;
  int low_c  = 0;
  logic ack_prev = 1'b1;

  function automatic void chk(string name, int act, int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               name, act, req, cyc);
    end
  endfunction

  // Monitor: one completed handshake per expected entry
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      ks_c = 0; be_c = 0; low_c = 0;
      ack_prev = 1'b1;
    end else begin
      if (ifc.key_strobe) ks_c++;
      if (ifc.byte_err)   be_c++;
      if (!ifc.ack)       low_c++;
      if (ifc.ack && !ack_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_note_idx",   int'(ifc.note_idx), e.idx);
          chk("sb_octave",     int'(ifc.octave),   e.oct);
          chk("sb_note_on",    int'(ifc.note_on),  e.on);
          chk("sb_key_strobe", ks_c,  e.ks);
          chk("sb_byte_err",   be_c,  e.be);
          chk("sb_ack_low",    low_c, e.low);
        end
        ks_c = 0; be_c = 0; low_c = 0;
      end
      ack_prev = ifc.ack;
    end
  end

  function automatic void expect_byte(int idx, int oct, int on,
                                      int ks, int be, int low);
    exp_t x;
    x.idx = idx; x.oct = oct; x.on = on;
    x.ks = ks; x.be = be; x.low = low;
    sb.push_back(x);
  endfunction

  // Called at a negedge; returns at a negedge once ack is back high.
  task automatic send(input logic [7:0] b, input int hold,
                      output int upd);
    int n;
    ifc.d_in  = b;
    ifc.ready = 1'b1;
    upd = cyc + 4;
    repeat (hold) @(negedge clk);
    ifc.ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ifc.ack !== 1'b1 && n < 20);
    if (ifc.ack !== 1'b1) chk("ack_timeout", 0, 1);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_fall(input string name, input int t);
    int n;
    n = 0;
    while (ifc.note_on === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, cyc, t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int u1, u2;
    ifc.d_in  = 8'h00;
    ifc.ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ack",        int'(ifc.ack),        1);
    chk("rst_note_on",    int'(ifc.note_on),    0);
    chk("rst_octave",     int'(ifc.octave),     1);
    chk("rst_note_idx",   int'(ifc.note_idx),   0);
    chk("rst_key_strobe", int'(ifc.key_strobe), 0);
    chk("rst_byte_err",   int'(ifc.byte_err),   0);

    // 'a' with a long ready pulse, then sustain release
    expect_byte(0, 1, 1, 1, 0, 40);
    send(8'h61, 40, u1);
    wait_fall("a_release", u1 + SUS);

    // 'e' retriggered 60 clocks after its first update
    repeat (5) @(negedge clk);
    expect_byte(3, 1, 1, 1, 0, 8);
    send(8'h65, 8, u1);
    wait_until(u1 + 56);
    expect_byte(3, 1, 1, 1, 0, 8);
    send(8'h65, 8, u2);
    chk("e_retrig_gap", u2 - u1, 60);
    wait_fall("e_release", u2 + SUS);

    // octave saturation both ways
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      expect_byte(3, 2, 0, 0, 0, 4);
      send(8'h2B, 4, u1);
    end
    expect_byte(3, 1, 0, 0, 0, 4);
    send(8'h2D, 4, u1);
    expect_byte(3, 0, 0, 0, 0, 4);
    send(8'h2D, 4, u1);
    expect_byte(3, 0, 0, 0, 0, 4);
    send(8'h2D, 4, u1);

    // 'k' then space 10 clocks later
    expect_byte(12, 0, 1, 1, 0, 4);
    send(8'h6B, 4, u1);
    wait_until(u1 + 6);
    chk("k_held", int'(ifc.note_on), 1);
    expect_byte(12, 0, 0, 0, 0, 4);
    send(8'h20, 4, u2);
    chk("space_gap", u2 - u1, 10);

    // unmapped uppercase byte
    expect_byte(12, 0, 0, 0, 1, 4);
    send(8'h5A, 4, u1);

    // 'g' aborted by reset while in DECODE
    ifc.d_in  = 8'h67;
    ifc.ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("g_captured", int'(ifc.ack), 0);
    rst       = 1'b1;
    ifc.ready = 1'b0;
    #1;
    chk("mid_rst_ack",      int'(ifc.ack),      1);
    chk("mid_rst_note_idx", int'(ifc.note_idx), 0);
    chk("mid_rst_octave",   int'(ifc.octave),   1);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_rst_ack",      int'(ifc.ack),      1);
    chk("post_rst_note_on",  int'(ifc.note_on),  0);
    chk("post_rst_note_idx", int'(ifc.note_idx), 0);
    chk("post_rst_octave",   int'(ifc.octave),   1);
    chk("sb_drained",        sb.size(),          0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
